// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-unit control inputs, instruction-memory handshake and PC outputs.
interface pc_fetch_unit_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset_sl2;
   logic        jump;
   logic [25:0] jump_index;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        timeout_err;
   modport master (
      input  stall, branch_taken, branch_offset_sl2, jump, jump_index, imem_ack,
      output imem_req, imem_addr, pc, pc_plus4, instr_valid, timeout_err
   );
   modport slave (
      output stall, branch_taken, branch_offset_sl2, jump, jump_index, imem_ack,
      input  imem_req, imem_addr, pc, pc_plus4, instr_valid, timeout_err
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and next-PC sequencer with imem request, stall hold,
// pending-redirect capture and ack-timeout retry.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          TIMEOUT      = 15
) (
   input logic              clk,
   input logic              rst_n,
   pc_fetch_unit_if.master  f
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, RETRY} state_e;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   state_e      state_q;
   logic [31:0] pc_q, pend_tgt_q, pc_d, pc_plus4, redir_tgt;
   logic [7:0]  wait_cnt_q;
   logic        pend_vld_q, timeout_err_q, pulse, in_req, advance;
   assign pc_plus4  = pc_q + 32'd4;
   assign pulse     = f.jump | f.branch_taken;
   assign redir_tgt = f.jump ? {pc_plus4[31:28], f.jump_index, 2'b00} : pc_plus4 + f.branch_offset_sl2;
   // a pulse on the advance cycle itself beats anything already pending
   assign pc_d      = pulse ? redir_tgt : pend_vld_q ? pend_tgt_q : pc_plus4;
   assign in_req    = state_q == REQ;
   assign advance   = !f.stall & ((in_req & f.imem_ack) | (state_q == HOLD));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_VECTOR;
         pend_tgt_q    <= '0;
         pend_vld_q    <= 1'b0;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= 1'b0;
         if (advance) begin
            pc_q       <= pc_d;
            pend_vld_q <= 1'b0;
         end else if (pulse) begin
            pend_vld_q <= 1'b1;
            pend_tgt_q <= redir_tgt;
         end
         case (state_q)
            IDLE: state_q <= REQ;
            REQ:
               if (f.imem_ack) begin
                  wait_cnt_q <= '0;
                  state_q    <= f.stall ? HOLD : REQ;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  wait_cnt_q    <= '0;
                  timeout_err_q <= 1'b1;
                  state_q       <= RETRY;
               end else wait_cnt_q <= wait_cnt_q + 8'd1;
            HOLD:  if (!f.stall) state_q <= REQ;
            RETRY: state_q <= REQ;
         endcase
      end
   end
   assign f.imem_req    = in_req;
   assign f.imem_addr   = pc_q;
   assign f.pc          = pc_q;
   assign f.pc_plus4    = pc_plus4;
   assign f.instr_valid = in_req & f.imem_ack;
   assign f.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic on two fetch units
// (different reset vectors / timeouts), checked against a behavioural model.
module tb_pc_fetch_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        stall = 0, branch_taken = 0, jump = 0, ack = 0;
   logic [31:0] off = 0;
   logic [25:0] ji = 0;
   int          checks = 0, failures = 0;
   logic [31:0] rv [2] = '{32'h0040_0000, 32'hFFFF_FFFC};
   int          to [2] = '{4, 15};
   logic [31:0] m_pc [2], m_pt [2];
   int          m_ph [2], m_cnt [2];
   bit          m_pv [2], m_terr [2];

   always #5 clk = ~clk;

   pc_fetch_unit_if fa ();
   pc_fetch_unit_if fb ();
   assign fa.stall = stall;  assign fa.branch_taken = branch_taken;  assign fa.branch_offset_sl2 = off;
   assign fa.jump = jump;    assign fa.jump_index = ji;              assign fa.imem_ack = ack;
   assign fb.stall = stall;  assign fb.branch_taken = branch_taken;  assign fb.branch_offset_sl2 = off;
   assign fb.jump = jump;    assign fb.jump_index = ji;              assign fb.imem_ack = ack;

   pc_fetch_unit #(.RESET_VECTOR(32'h0040_0000), .TIMEOUT(4)) u_a (.clk(clk), .rst_n(rst_n), .f(fa));
   pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .TIMEOUT(15)) u_b (.clk(clk), .rst_n(rst_n), .f(fb));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = rv[k]; m_pt[k] = '0; m_ph[k] = 0; m_cnt[k] = 0; m_pv[k] = 0; m_terr[k] = 0;
      end
   endtask

   // phases: 0 idle, 1 requesting, 2 holding on stall, 3 retry gap
   task automatic mstep(input int k);
      logic [31:0] p4, tgt;
      bit adv, pulse;
      p4    = m_pc[k] + 32'd4;
      pulse = jump || branch_taken;
      tgt   = jump ? {p4[31:28], ji, 2'b00} : p4 + off;
      adv   = !stall && ((m_ph[k] == 1 && ack) || m_ph[k] == 2);
      m_terr[k] = 0;
      if (m_ph[k] == 1 && !ack) begin
         if (m_cnt[k] == to[k] - 1) begin m_terr[k] = 1; m_ph[k] = 3; m_cnt[k] = 0; end
         else m_cnt[k]++;
      end else begin
         m_cnt[k] = 0;
         m_ph[k]  = ((m_ph[k] == 1 || m_ph[k] == 2) && stall) ? 2 : 1;
      end
      if (adv) begin
         m_pc[k] = pulse ? tgt : m_pv[k] ? m_pt[k] : p4;
         m_pv[k] = 0;
      end else if (pulse) begin
         m_pv[k] = 1; m_pt[k] = tgt;
      end
   endtask

   task automatic mchk(input int k, input logic req, input logic [31:0] addr, input logic [31:0] pc,
                       input logic [31:0] p4, input logic val, input logic terr);
      chk($sformatf("m%0d_req", k),   32'(req),  32'(m_ph[k] == 1));
      chk($sformatf("m%0d_addr", k),  addr,      m_pc[k]);
      chk($sformatf("m%0d_pc", k),    pc,        m_pc[k]);
      chk($sformatf("m%0d_p4", k),    p4,        m_pc[k] + 32'd4);
      chk($sformatf("m%0d_valid", k), 32'(val),  32'(m_ph[k] == 1 && ack));
      chk($sformatf("m%0d_terr", k),  32'(terr), 32'(m_terr[k]));
   endtask

   // called at a falling edge; leaves the bench at the next falling edge
   task automatic cyc(input logic a, input logic s = 0, input logic b = 0, input logic [31:0] o = 0,
                      input logic j = 0, input logic [25:0] jx = 0);
      ack = a; stall = s; branch_taken = b; off = o; jump = j; ji = jx;
      #1;
      mchk(0, fa.imem_req, fa.imem_addr, fa.pc, fa.pc_plus4, fa.instr_valid, fa.timeout_err);
      mchk(1, fb.imem_req, fb.imem_addr, fb.pc, fb.pc_plus4, fb.instr_valid, fb.timeout_err);
      @(posedge clk);
      mstep(0); mstep(1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mreset();
      repeat (2) @(negedge clk);
      chk("rst_pc_a", fa.pc, 32'h0040_0000);
      chk("rst_req_a", 32'(fa.imem_req), 0);
      chk("rst_pc_b", fb.pc, 32'hFFFF_FFFC);
      chk("rst_terr_a", 32'(fa.timeout_err), 0);
      rst_n = 1'b1;
      // 1: one idle cycle, then sequential fetch
      chk("t1_idle_req", 32'(fa.imem_req), 0);
      cyc(1);
      chk("t1_addr0", fa.imem_addr, 32'h0040_0000);
      chk("t1_req", 32'(fa.imem_req), 1);
      cyc(1);
      chk("t1_addr1", fa.imem_addr, 32'h0040_0004);
      chk("t6_wrap", fb.pc, 32'h0000_0000);
      cyc(1);
      chk("t1_addr2", fa.imem_addr, 32'h0040_0008);
      cyc(1); cyc(1);
      chk("t2_start", fa.pc, 32'h0040_0010);
      // 2: backward and forward branches
      cyc(1, 0, 1, 32'hFFFF_FFF0);
      chk("t2_back", fa.imem_addr, 32'h0040_0004);
      cyc(1); cyc(1); cyc(1);
      cyc(1, 0, 1, 32'h0000_0010);
      chk("t2_fwd", fa.imem_addr, 32'h0040_0024);
      // 3: jump beats branch in the same advance
      cyc(1, 0, 1, 32'h0FBF_FFD8);
      chk("t3_start", fa.pc, 32'h1000_0000);
      cyc(1, 0, 1, 32'h0000_0044, 1, 26'h40);
      chk("t3_jump", fa.imem_addr, 32'h1000_0100);
      // 4: stall hold with a branch latched mid-stall
      cyc(1, 0, 1, 32'hEFFF_FFFC);
      chk("t4_start", fa.pc, 32'h0000_0100);
      cyc(1, 1);
      chk("t4_hold_req1", 32'(fa.imem_req), 0);
      cyc(0, 1, 1, 32'h0000_0020);
      chk("t4_hold_pc2", fa.pc, 32'h0000_0100);
      cyc(0, 1);
      chk("t4_hold_req3", 32'(fa.imem_req), 0);
      chk("t4_hold_pc3", fa.pc, 32'h0000_0100);
      cyc(0, 0);
      chk("t4_release_pc", fa.pc, 32'h0000_0124);
      chk("t4_release_req", 32'(fa.imem_req), 1);
      // 5: timeout after four unacknowledged request cycles
      cyc(0); cyc(0); cyc(0);
      chk("t5_no_terr_yet", 32'(fa.timeout_err), 0);
      cyc(0);
      chk("t5_terr", 32'(fa.timeout_err), 1);
      chk("t5_retry_req", 32'(fa.imem_req), 0);
      cyc(0);
      chk("t5_terr_once", 32'(fa.timeout_err), 0);
      chk("t5_rereq_addr", fa.imem_addr, 32'h0000_0124);
      chk("t5_rereq", 32'(fa.imem_req), 1);
      cyc(1);
      chk("t5_advance", fa.pc, 32'h0000_0128);
      // randomized traffic
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
             ($urandom_range(0, 1) != 0) ? $urandom : {{20{1'b0}}, 10'($urandom), 2'b00},
             $urandom_range(0, 19) == 0, 26'($urandom));
      // 6: asynchronous reset in the middle of a request cycle
      for (int i = 0; i < 8 && m_ph[0] != 1; i++) cyc(0);
      chk("t6_in_req", 32'(fa.imem_req), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_pc_a", fa.pc, 32'h0040_0000);
      chk("t6_async_req_a", 32'(fa.imem_req), 0);
      chk("t6_async_pc_b", fb.pc, 32'hFFFF_FFFC);
      chk("t6_async_req_b", 32'(fb.imem_req), 0);
      mreset();
      @(negedge clk);
      rst_n = 1'b1;
      ack = 1'b1;
      #1;
      chk("t6_idle_ack_ignored", 32'(fa.instr_valid), 0);
      cyc(1); cyc(1);
      chk("t6_restart", fa.imem_addr, 32'h0040_0004);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
